// File: rtl/wr_port_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ streams.
// Optional macro WR_ARB_STALL_CNT_EN adds a saturating 16-bit full-stall counter.
module wr_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wfull,
  output logic                         winc,
  output logic [DATA_SIZE-1:0]         wdata,
`ifdef WR_ARB_STALL_CNT_EN
  output logic [15:0]                  stall_cnt,
`endif
  output logic [NUM_REQ-1:0]           gnt
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);
  localparam logic [OW-1:0] OWN_RST = OW'(NUM_REQ - 1);
  localparam logic [OW:0] NREQ = (OW+1)'(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [OW-1:0]      own, own_nxt;
  logic [BW-1:0]      bcnt, bcnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               burst, bend, arb;
  logic               found;
  logic [OW-1:0]      win;
  logic [OW:0]        sum;

  assign burst     = (state == BURST);
  assign req_ready = (burst && !wfull) ? gnt : '0;
  assign winc      = |(req_valid & req_ready);
  assign wdata     = winc ?
    req_data[int'(own)*DATA_SIZE +: DATA_SIZE] : '0;

  // Round-robin search starting just after the current owner
  always_comb begin
    found = 1'b0;
    win   = own;
    sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, own} + (OW+1)'(k);
      if (sum >= NREQ)
        sum = sum - NREQ;
      if (!found && req_valid[sum[OW-1:0]]) begin
        found = 1'b1;
        win   = sum[OW-1:0];
      end
    end
  end

  // Burst end detection, re-arbitration and burst counting
  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    gnt_nxt   = gnt;
    bcnt_nxt  = bcnt;
    bend      = 1'b0;
    if (burst)
      bend = !req_valid[own] || (winc && bcnt == BLAST);
    arb = !burst || bend;
    if (arb) begin
      bcnt_nxt = '0;
      if (found) begin
        state_nxt = BURST;
        own_nxt   = win;
        gnt_nxt   = '0;
        gnt_nxt[win] = 1'b1;
      end else begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    end else if (winc) begin
      bcnt_nxt = bcnt + BW'(1);
    end
  end

  // State, owner, grant and burst counter registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
      own   <= OWN_RST;
      bcnt  <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      own   <= own_nxt;
      bcnt  <= bcnt_nxt;
      gnt   <= gnt_nxt;
    end
  end

`ifdef WR_ARB_STALL_CNT_EN
  // Count cycles where the owner has a word but the FIFO is full
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)
      stall_cnt <= '0;
    else if (burst && req_valid[own] && wfull &&
             stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Self-checking bench for wr_port_arbiter: grant-level model plus
// directed scenarios and a randomized soak.
module tb_wr_port_arbiter;

  localparam int NR = 4;
  localparam int DS = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DS-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic wfull = 1'b0;
  logic winc;
  logic [DS-1:0] wdata;
  logic [NR-1:0] gnt;
`ifdef WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  wr_port_arbiter #(
    .NUM_REQ(NR), .DATA_SIZE(DS), .MAX_BURST(MB)
  ) dut (
    .wclk(clk),
    .wrst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .wfull(wfull),
    .winc(winc),
    .wdata(wdata),
`ifdef WR_ARB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .gnt(gnt)
  );

  int ntest = 0;
  int nfail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(int from, logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(from + k) % NR]) return (from + k) % NR;
    return -1;
  endfunction

  // Model: who holds the port and how many words it has moved this grant
  bit          m_act;
  int          m_own;
  int          m_taken;
  int          m_stall;
  logic [NR-1:0] acc;
  logic [NR-1:0] eg, er;
  logic        ew;
  int          p, cyc, gi;
  int          log_own[$];
  int          log_dat[$];
  int          log_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_ready", 32'(req_ready), 32'(0));
      chk("rst_winc", 32'(winc), 32'(0));
      chk("rst_wdata", 32'(wdata), 32'(0));
`ifdef WR_ARB_STALL_CNT_EN
      chk("rst_stall", 32'(stall_cnt), 32'(0));
`endif
      m_act = 0;
      m_own = NR - 1;
      m_taken = 0;
      m_stall = 0;
      acc = '0;
    end else begin
      eg = '0;
      if (m_act) eg[m_own] = 1'b1;
      er = (m_act && !wfull) ? eg : '0;
      ew = |(req_valid & er);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("winc", 32'(winc), 32'(ew));
      if (ew)
        chk("wdata", 32'(wdata), 32'(req_data[m_own*DS +: DS]));
`ifdef WR_ARB_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (m_act && req_valid[m_own] && wfull && m_stall < 65535)
        m_stall++;
`endif
      if (winc) begin
        gi = -1;
        for (int i = 0; i < NR; i++) if (gnt[i]) gi = i;
        log_own.push_back(gi);
        log_dat.push_back(int'(wdata));
        log_cyc.push_back(cyc);
      end
      acc = req_valid & er;
      if (ew) m_taken++;
      if (!m_act || !req_valid[m_own] || m_taken == MB) begin
        p = pick(m_own, req_valid);
        if (p < 0) m_act = 0;
        else begin
          m_act = 1;
          m_own = p;
          m_taken = 0;
        end
      end
    end
  end

  // Requester sources: left words each, data increments on acceptance
  int   left[NR];
  logic [DS-1:0] cur[NR];
  bit   rnd = 0;
  logic full_next = 1'b0;

  task automatic feed();
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        left[i]--;
        cur[i] = cur[i] + 8'd1;
      end
      if (rnd && left[i] == 0 && $urandom_range(0, 3) == 0) begin
        left[i] = $urandom_range(1, 9);
        cur[i] = 8'($urandom);
      end
      req_valid[i] = (left[i] > 0);
      req_data[i*DS +: DS] = cur[i];
    end
    wfull = rnd ? ($urandom_range(0, 4) == 0) : full_next;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    feed();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    feed();
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'(0));
    chk("arst_winc", 32'(winc), 32'(0));
    chk("arst_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    #1;
    step();
    step();
    @(posedge clk);
    #1;
    feed();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    log_own.delete();
    log_dat.delete();
    log_cyc.delete();
  endtask

  task automatic set_left(int a, int b, int c, int d);
    left[0] = a; left[1] = b; left[2] = c; left[3] = d;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      left[i] = 1;
      cur[i] = 8'(i);
    end
    feed();
    step();
    step();
    chk("hold_rst_gnt", 32'(gnt), 32'(0));
    @(posedge clk);
    #1;
    feed();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    step();
    chk("first_gnt", 32'(gnt), 32'h1);

    // Single requester 2 streams 10 words
    set_left(0, 0, 10, 0);
    cur[2] = 8'hA0;
    do_reset();
    repeat (14) step();
    chk("single_count", 32'(log_own.size()), 32'd10);
    if (log_own.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        chk("single_own", 32'(log_own[k]), 32'd2);
        chk("single_data", 32'(log_dat[k]), 32'(8'hA0 + k));
      end
      chk("single_gapless", 32'(log_cyc[9] - log_cyc[0]), 32'd9);
    end
    chk("single_idle", 32'(gnt), 32'h0);

    // All four continuously valid: 0,1,2,3,0 in bursts of 4
    set_left(100, 100, 100, 100);
    do_reset();
    repeat (22) step();
    chk("rr_count_ge20", 32'(log_own.size() >= 20), 32'd1);
    if (log_own.size() >= 20) begin
      for (int k = 0; k < 20; k++)
        chk("rr_order", 32'(log_own[k]), 32'((k / 4) % 4));
      chk("rr_gapless", 32'(log_cyc[19] - log_cyc[0]), 32'd19);
    end

    // Full stall after the 2nd word of a burst
    set_left(10, 0, 0, 1);
    cur[0] = 8'h10;
    cur[3] = 8'h30;
    do_reset();
    for (int t = 0; t < 10 && log_own.size() < 2; t++) step();
    chk("full_pre", 32'(log_own.size()), 32'd2);
    full_next = 1'b1;
    repeat (5) step();
    chk("full_hold", 32'(log_own.size()), 32'd2);
    full_next = 1'b0;
    repeat (3) step();
    chk("full_after", 32'(log_own.size()), 32'd5);
    if (log_own.size() == 5) begin
      chk("full_w3_own", 32'(log_own[2]), 32'd0);
      chk("full_w4_own", 32'(log_own[3]), 32'd0);
      chk("full_w3_dat", 32'(log_dat[2]), 32'h12);
      chk("full_w4_dat", 32'(log_dat[3]), 32'h13);
      chk("full_next_own", 32'(log_own[4]), 32'd3);
    end
    chk("full_gnt3", 32'(gnt), 32'h8);
`ifdef WR_ARB_STALL_CNT_EN
    chk("full_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // Owner 1 drops valid after one word while 3 waits
    set_left(0, 1, 0, 5);
    do_reset();
    step();
    chk("drop_gnt1", 32'(gnt), 32'h2);
    step();
    step();
    chk("drop_gnt3", 32'(gnt), 32'h8);

    // Reset pulse mid-burst
    set_left(50, 50, 50, 50);
    do_reset();
    step();
    step();
    chk("mid_gnt", 32'(gnt), 32'h1);
    do_reset();
    step();
    chk("mid_regnt", 32'(gnt), 32'h1);

    // Randomized soak against the model
    set_left(0, 0, 0, 0);
    rnd = 1;
    do_reset();
    repeat (3000) step();
    rnd = 0;

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
